dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001 The block SHALL have parameter XLEN, default 64, setting address and data width in bits.
- REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
- REQ-004 The block SHALL have port m0_req / m1_req, input, 1, requester n wants an access.
- REQ-005 The block SHALL have port m0_we / m1_we, input, 1, the access is a write (1) or a read (0).
- REQ-006 The block SHALL have port m0_addr / m1_addr, input, XLEN, byte address.
- REQ-007 The block SHALL have port m0_wdata / m1_wdata, input, XLEN, write data.
- REQ-008 The block SHALL have port m0_gnt / m1_gnt, output, 1, request accepted this cycle.
- REQ-009 The block SHALL have port m0_rvalid / m1_rvalid, output, 1, one-cycle completion pulse for both reads and writes.
- REQ-010 The block SHALL have port m0_rdata / m1_rdata, output, XLEN, read data, valid only with rvalid.
- REQ-011 The block SHALL have port m0_err / m1_err, output, 1, misaligned-access error, valid only with rvalid.
- REQ-012 The block SHALL have ports mem_address and mem_write_data, output, XLEN each, driven to data memory.
- REQ-013 The block SHALL have ports mem_write_en and mem_read_en, output, 1 each, memory strobes.
- REQ-014 The block SHALL have port mem_read_data, input, XLEN, combinational read data from memory.

Function
- REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
- REQ-016 In IDLE with at least one req high, the block SHALL assert gnt combinationally to exactly one winner, capture that winner's we, addr, wdata and id, and move to ACCESS.
- REQ-017 In IDLE with no req high, the FSM SHALL stay in IDLE.
- REQ-018 gnt SHALL be asserted only in IDLE and never to both requesters in the same cycle.
- REQ-019 In ACCESS with captured addr[2:0]==0, the block SHALL drive mem_address and mem_write_data from the captured values and assert mem_write_en=we or mem_read_en=!we for exactly one cycle.
- REQ-020 At the end of an ACCESS read, the block SHALL register mem_read_data.
- REQ-021 In ACCESS with captured addr[2:0]!=0, the block SHALL keep both memory strobes low and flag an error.
- REQ-022 The block SHALL always move from ACCESS to RESP.
- REQ-023 In RESP, the block SHALL pulse the owner's rvalid for one cycle, with rdata = registered data for an aligned read and 0 otherwise, and err = misaligned flag.
- REQ-024 The block SHALL always move from RESP to IDLE.
- REQ-025 Latency SHALL be: gnt in cycle N, memory strobe in N+1, rvalid in N+2; the next gnt can occur no earlier than N+3.
- REQ-026 The non-owner's rvalid SHALL stay 0, and all memory outputs SHALL be 0 outside ACCESS.
- REQ-027 A requester SHALL hold its request fields stable while req is high and not granted; a req dropped before gnt SHALL have no effect.
- REQ-028 Request inputs SHALL be ignored in ACCESS and RESP; pending requests wait for the next IDLE.
- REQ-029 Address arithmetic SHALL be a pass-through with no increment; memory-side wrap-around is the memory's concern.

Reset
- REQ-030 When rstn is low, the FSM SHALL enter IDLE immediately, regardless of clk.
- REQ-031 When rstn is low, the priority pointer SHALL point to m0, captured registers SHALL clear, and all outputs SHALL be 0, including mem_write_en during a reset asserted mid-ACCESS.
- REQ-032 An access interrupted by reset SHALL produce no rvalid.

Configuration
- REQ-033 With DMEM_ARB_RR_EN defined, the block SHALL arbitrate round-robin, updating the priority pointer to the non-winner on each gnt.
- REQ-034 Without DMEM_ARB_RR_EN defined, the block SHALL use fixed priority with m0 always winning a simultaneous request and no pointer register.

Verification
- REQ-035 Read: m0 reads addr 0x10, memory returns 0x1122334455667788 -> m0_gnt at N, mem_read_en at N+1, m0_rvalid at N+2 with rdata 0x1122334455667788 and err=0.
- REQ-036 Write: m1 writes 0xDEADBEEF to addr 0x8 -> mem_write_en with mem_address 0x8 at N+1, m1_rvalid at N+2 with rdata 0 and err=0.
- REQ-037 Contention: both req high for 9 cycles -> with RR_EN, grants alternate m0,m1,m0; without it, m0 gets all 3.
- REQ-038 Misaligned: m0 reads 0x13 -> no memory strobe, m0_rvalid with err=1 and rdata=0.
- REQ-039 Reset mid-op: rstn low during ACCESS of a write -> mem_write_en drops immediately, no rvalid follows, and the next access after release is granted to m0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP per transaction.
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration; otherwise m0
// has fixed priority and no pointer register exists.
module dmem_arbiter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_err,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read_en,
  input  logic [XLEN-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic              id_q;
  logic              err_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              any_req;
  logic              win_id;
  logic              take;
  logic              misalign;

  assign any_req  = m0_req | m1_req;
  assign misalign = (addr_q[2:0] != 3'b000);
  // A grant is taken only in IDLE and never while reset is held
  assign take     = rstn & any_req & (state_q == IDLE);

`ifdef DMEM_ARB_RR_EN
  logic prio_q;

  // Winner selection: pointer breaks ties, a lone requester always wins
  always_comb begin
    win_id = (m0_req & m1_req) ? prio_q : ~m0_req;
  end

  // Pointer moves to the non-winner on every grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q <= 1'b0;
    end else if (take) begin
      prio_q <= ~win_id;
    end
  end
`else
  // Winner selection: m0 always wins a tie
  always_comb begin
    win_id = ~m0_req;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on grant, read data and error capture at end of ACCESS
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (take) begin
      id_q    <= win_id;
      we_q    <= win_id ? m1_we    : m0_we;
      addr_q  <= win_id ? m1_addr  : m0_addr;
      wdata_q <= win_id ? m1_wdata : m0_wdata;
    end else if (state_q == ACCESS) begin
      err_q   <= misalign;
      rdata_q <= (!we_q && !misalign) ? mem_read_data : '0;
    end
  end

  // Output decode: grants in IDLE, memory strobes in ACCESS, completion in RESP
  always_comb begin
    m0_gnt         = 1'b0;
    m1_gnt         = 1'b0;
    m0_rvalid      = 1'b0;
    m1_rvalid      = 1'b0;
    m0_rdata       = '0;
    m1_rdata       = '0;
    m0_err         = 1'b0;
    m1_err         = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    case (state_q)
      IDLE: begin
        m0_gnt = take & ~win_id;
        m1_gnt = take & win_id;
      end
      ACCESS: begin
        if (!misalign) begin
          mem_address    = addr_q;
          mem_write_data = wdata_q;
          mem_write_en   = we_q;
          mem_read_en    = ~we_q;
        end
      end
      RESP: begin
        if (id_q) begin
          m1_rvalid = 1'b1;
          m1_rdata  = rdata_q;
          m1_err    = err_q;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = rdata_q;
          m0_err    = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-latency model checked every cycle on the
// falling edge, plus literal checks for the read/write/contention/misaligned
// and reset-mid-access scenarios.
module tb_dmem_arbiter;

  logic        clk;
  logic        rstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of address
  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h10) return 64'h1122334455667788;
    return a * 64'h9E3779B97F4A7C15 + 64'h5;
  endfunction

  assign mem_read_data = mem_fn(mem_address);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a grant at cycle G implies strobe at G+1, completion at G+2, free at G+3
  int          cyc = 0;
  int          g_cyc = 0;
  bit          busy = 0;
  bit          ptr = 0;
  bit          md_id, md_we;
  logic [63:0] md_addr, md_wdata;

  always @(negedge clk) begin
    logic        e_g0, e_g1, e_rv0, e_rv1, e_er0, e_er1, e_we, e_re;
    logic [63:0] e_rd0, e_rd1, e_ma, e_wd;
    bit          win, aligned;
    int          age;
    e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_er0 = 0; e_er1 = 0;
    e_we = 0; e_re = 0; e_rd0 = 0; e_rd1 = 0; e_ma = 0; e_wd = 0;
    cyc++;
    if (!rstn) begin
      busy = 0;
      ptr  = 0;
    end else begin
      age = cyc - g_cyc;
      if (busy && age >= 3) busy = 0;
      aligned = (md_addr % 8) == 0;
      if (!busy) begin
        if (m0_req || m1_req) begin
`ifdef DMEM_ARB_RR_EN
          win = (m0_req && m1_req) ? ptr : !m0_req;
`else
          win = !m0_req;
`endif
          ptr      = !win;
          e_g0     = !win;
          e_g1     = win;
          busy     = 1;
          g_cyc    = cyc;
          md_id    = win;
          md_we    = win ? m1_we : m0_we;
          md_addr  = win ? m1_addr : m0_addr;
          md_wdata = win ? m1_wdata : m0_wdata;
        end
      end else if (age == 1) begin
        if (aligned) begin
          e_ma = md_addr;
          e_wd = md_wdata;
          e_we = md_we;
          e_re = !md_we;
        end
      end else if (age == 2) begin
        if (md_id) begin
          e_rv1 = 1; e_er1 = !aligned;
          e_rd1 = (!md_we && aligned) ? mem_fn(md_addr) : 64'h0;
        end else begin
          e_rv0 = 1; e_er0 = !aligned;
          e_rd0 = (!md_we && aligned) ? mem_fn(md_addr) : 64'h0;
        end
      end
    end
    chk("m0_gnt", m0_gnt, e_g0);
    chk("m1_gnt", m1_gnt, e_g1);
    chk("m0_rvalid", m0_rvalid, e_rv0);
    chk("m1_rvalid", m1_rvalid, e_rv1);
    chk("m0_err", m0_err, e_er0);
    chk("m1_err", m1_err, e_er1);
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
    chk("mem_address", mem_address, e_ma);
    chk("mem_write_data", mem_write_data, e_wd);
    chk("mem_write_en", mem_write_en, e_we);
    chk("mem_read_en", mem_read_en, e_re);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int grants[$];
    int exp_g[3];
    rstn = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    #2;
    m0_req = 1;
    #1 chk("rst_gnt_gated", m0_gnt, 1'b0);
    m0_req = 0;
    repeat (2) tick();
    rstn = 1;
    tick();

    // Contention: both requesters held high for 9 cycles
    m0_req = 1; m0_we = 0; m0_addr = 64'h18;
    m1_req = 1; m1_we = 1; m1_addr = 64'h28; m1_wdata = 64'h55;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (m0_gnt) grants.push_back(0);
      if (m1_gnt) grants.push_back(1);
      tick();
    end
    m0_req = 0; m1_req = 0;
`ifdef DMEM_ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0;
`endif
    chk("cont_count", 64'(grants.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("cont_order", (i < grants.size()) ? 64'(grants[i]) : 64'hFF, 64'(exp_g[i]));
    tick(); tick();

    // Aligned read by m0
    m0_req = 1; m0_we = 0; m0_addr = 64'h10;
    #1 chk("rd_gnt", m0_gnt, 1'b1);
    tick();
    m0_req = 0;
    #1 chk("rd_ren", mem_read_en, 1'b1);
    chk("rd_addr", mem_address, 64'h10);
    tick();
    #1 chk("rd_rvalid", m0_rvalid, 1'b1);
    chk("rd_rdata", m0_rdata, 64'h1122334455667788);
    chk("rd_err", m0_err, 1'b0);
    tick();

    // Aligned write by m1
    m1_req = 1; m1_we = 1; m1_addr = 64'h8; m1_wdata = 64'hDEADBEEF;
    #1 chk("wr_gnt", m1_gnt, 1'b1);
    tick();
    m1_req = 0;
    #1 chk("wr_wen", mem_write_en, 1'b1);
    chk("wr_addr", mem_address, 64'h8);
    chk("wr_data", mem_write_data, 64'hDEADBEEF);
    tick();
    #1 chk("wr_rvalid", m1_rvalid, 1'b1);
    chk("wr_rdata", m1_rdata, 64'h0);
    chk("wr_err", m1_err, 1'b0);
    tick();

    // Misaligned read by m0
    m0_req = 1; m0_we = 0; m0_addr = 64'h13;
    tick();
    m0_req = 0;
    #1 chk("mis_ren", mem_read_en, 1'b0);
    chk("mis_wen", mem_write_en, 1'b0);
    tick();
    #1 chk("mis_rvalid", m0_rvalid, 1'b1);
    chk("mis_err", m0_err, 1'b1);
    chk("mis_rdata", m0_rdata, 64'h0);
    tick();

    // Reset asserted during the ACCESS cycle of a write
    m0_req = 1; m0_we = 1; m0_addr = 64'h20; m0_wdata = 64'hABCD;
    #1 chk("rm_gnt", m0_gnt, 1'b1);
    tick();
    m0_req = 0;
    #1 chk("rm_wen_before", mem_write_en, 1'b1);
    rstn = 0;
    #1 chk("rm_wen_after", mem_write_en, 1'b0);
    tick(); tick();
    rstn = 1;
    #1 chk("rm_no_rvalid", m0_rvalid, 1'b0);
    tick();
    #1 chk("rm_no_rvalid2", m0_rvalid, 1'b0);
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 64'h30;
    m1_req = 1; m1_we = 0; m1_addr = 64'h38;
    #1 chk("rm_next_m0", m0_gnt, 1'b1);
    chk("rm_next_m1", m1_gnt, 1'b0);
    tick();
    m0_req = 0; m1_req = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
